// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared ISA constants and fetch state encoding
package isa_pkg;

    localparam logic [15:0] NOP      = 16'h0800;
    localparam logic [4:0]  HALT_OP  = 5'b00000;
    localparam logic [15:0] RESET_PC = 16'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - IF/ID pipeline register with flush, hold and bubble controls
module ifid_reg
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic        bubble,
    input  logic [15:0] instr_in,
    input  logic [15:0] pcplus2_in,
    output logic [15:0] instr,
    output logic [15:0] pcplus2,
    output logic        valid
);

    // Flush beats hold so a redirect is never lost behind a stall; pcplus2 is
    // left untouched on flush/bubble since it is meaningless while valid is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr   <= NOP;
            pcplus2 <= RESET_PC;
            valid   <= 1'b0;
        end else if (flush) begin
            instr <= NOP;
            valid <= 1'b0;
        end else if (load) begin
            if (bubble) begin
                instr <= NOP;
                valid <= 1'b0;
            end else begin
                instr   <= instr_in;
                pcplus2 <= pcplus2_in;
                valid   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_ifid.sv
// rtl/fetch_ifid.sv - PC, RUN/HALTED fetch FSM and IF/ID stage; FETCH_STALL_CNT_EN adds stall_cnt
module fetch_ifid
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enPC,
    input  logic        enIFID,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    output logic [15:0] instr_IFID,
    output logic [15:0] pcplus2_IFID,
    output logic        valid_IFID,
    output logic [2:0]  RegRead_IFID_1,
    output logic [2:0]  RegRead_IFID_2,
    output logic        halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    state_t      state, state_nxt;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        fetch_ok;
    logic        is_halt;
    logic        halt_load;

    assign pc_plus2  = pc + 16'd2;
    assign fetch_ok  = imem_valid && (state == RUN);
    assign is_halt   = (imem_data[15:11] == HALT_OP);
    assign halt_load = !redirect && enIFID && fetch_ok && is_halt;
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

    // A fetched HALT freezes the PC at its own address, so the halted PC
    // points at the HALT rather than past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (enPC && fetch_ok && !is_halt) begin
            pc <= pc_plus2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (halt_load) state_nxt = HALTED;
            HALTED:  if (redirect)  state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    ifid_reg u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .load       (enIFID),
        .bubble     (!fetch_ok),
        .instr_in   (imem_data),
        .pcplus2_in (pc_plus2),
        .instr      (instr_IFID),
        .pcplus2    (pcplus2_IFID),
        .valid      (valid_IFID)
    );

    assign RegRead_IFID_1 = instr_IFID[10:8];
    assign RegRead_IFID_2 = instr_IFID[7:5];

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'h0000;
        end else if ((state == RUN) && (!enPC || !imem_valid) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ifid.sv
// tb/tb_fetch_ifid.sv - directed self-checking bench for fetch_ifid
module tb_fetch_ifid;

    logic        clk;
    logic        rst_n;
    logic        enPC;
    logic        enIFID;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [15:0] instr_IFID;
    logic [15:0] pcplus2_IFID;
    logic        valid_IFID;
    logic [2:0]  RegRead_IFID_1;
    logic [2:0]  RegRead_IFID_2;
    logic        halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    logic        halt_en;
    int          n_vec;
    int          n_err;

    fetch_ifid dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enPC           (enPC),
        .enIFID         (enIFID),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .imem_valid     (imem_valid),
        .instr_IFID     (instr_IFID),
        .pcplus2_IFID   (pcplus2_IFID),
        .valid_IFID     (valid_IFID),
        .RegRead_IFID_1 (RegRead_IFID_1),
        .RegRead_IFID_2 (RegRead_IFID_2),
        .halted         (halted)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: HALT (0x0345) at 0x0020 when enabled, else 0xA000 | addr[10:0].
    always_comb begin
        if (halt_en && imem_addr == 16'h0020) imem_data = 16'h0345;
        else                                   imem_data = 16'hA000 | {5'b00000, imem_addr[10:0]};
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                            input logic vld);
        chk({tag, "_pc"},    imem_addr,  pc);
        chk({tag, "_instr"}, instr_IFID, ins);
        chk({tag, "_valid"}, {15'd0, valid_IFID}, {15'd0, vld});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; enPC = 1'b1; enIFID = 1'b1; redirect = 1'b0;
        redirect_pc = 16'h0000; imem_valid = 1'b1; halt_en = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_ifid("rst", 16'h0000, 16'h0800, 1'b0);
        chk("rst_pcplus2", pcplus2_IFID, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'h0000);

        // Release: fetch 0x0000, 0x0002, 0x0004
        rst_n = 1'b1;
        chk("rel_c0_pc", imem_addr, 16'h0000);
        step();
        chk_ifid("rel_c1", 16'h0002, 16'hA000, 1'b1);
        chk("rel_c1_pcplus2", pcplus2_IFID, 16'h0002);
        step();
        chk_ifid("rel_c2", 16'h0004, 16'hA002, 1'b1);
        chk("rel_c2_pcplus2", pcplus2_IFID, 16'h0004);

        // Two-cycle stall at PC=0x0010
        redirect = 1'b1; redirect_pc = 16'h000E;
        step();
        chk_ifid("rd0e", 16'h000E, 16'h0800, 1'b0);
        redirect = 1'b0;
        step();
        chk_ifid("pre_stall", 16'h0010, 16'hA00E, 1'b1);
        enPC = 1'b0; enIFID = 1'b0;
        step();
        chk_ifid("stall1", 16'h0010, 16'hA00E, 1'b1);
        step();
        chk_ifid("stall2", 16'h0010, 16'hA00E, 1'b1);
        enPC = 1'b1; enIFID = 1'b1;
        step();
        chk_ifid("resume", 16'h0012, 16'hA010, 1'b1);
        chk("resume_pcplus2", pcplus2_IFID, 16'h0012);

        // Redirect wins over simultaneous stall
        enPC = 1'b0; enIFID = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        chk_ifid("rd_stall", 16'h0040, 16'h0800, 1'b0);
        redirect = 1'b0; enPC = 1'b1; enIFID = 1'b1;
        step();
        chk_ifid("after_rd", 16'h0042, 16'hA040, 1'b1);

        // Memory wait: three bubbles, PC holds
        imem_valid = 1'b0;
        step();
        chk_ifid("wait1", 16'h0042, 16'h0800, 1'b0);
        step();
        chk_ifid("wait2", 16'h0042, 16'h0800, 1'b0);
        step();
        chk_ifid("wait3", 16'h0042, 16'h0800, 1'b0);
        imem_valid = 1'b1;
        step();
        chk_ifid("wait_end", 16'h0044, 16'hA042, 1'b1);

        // HALT at 0x0020, then redirect to 0x0008
        halt_en = 1'b1; redirect = 1'b1; redirect_pc = 16'h001E;
        step();
        redirect = 1'b0;
        step();
        chk_ifid("pre_halt", 16'h0020, 16'hA01E, 1'b1);
        chk("pre_halt_halted", {15'd0, halted}, 16'h0000);
        step();
        chk_ifid("halt_in", 16'h0020, 16'h0345, 1'b1);
        chk("halt_in_halted", {15'd0, halted}, 16'h0001);
        chk("halt_in_pcplus2", pcplus2_IFID, 16'h0022);
        chk("halt_rr1", {13'd0, RegRead_IFID_1}, 16'h0003);
        chk("halt_rr2", {13'd0, RegRead_IFID_2}, 16'h0002);
        step();
        chk_ifid("halted1", 16'h0020, 16'h0800, 1'b0);
        chk("halted1_halted", {15'd0, halted}, 16'h0001);
        step();
        chk_ifid("halted2", 16'h0020, 16'h0800, 1'b0);
        chk("halted2_halted", {15'd0, halted}, 16'h0001);
        redirect = 1'b1; redirect_pc = 16'h0008;
        step();
        chk_ifid("unhalt", 16'h0008, 16'h0800, 1'b0);
        chk("unhalt_halted", {15'd0, halted}, 16'h0000);
        redirect = 1'b0; halt_en = 1'b0;
        step();
        chk_ifid("unhalt_run", 16'h000A, 16'hA008, 1'b1);

        // PC wrap at 0xFFFE
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step();
        chk("wrap_pre_pc", imem_addr, 16'hFFFE);
        redirect = 1'b0;
        step();
        chk_ifid("wrap", 16'h0000, 16'hA7FE, 1'b1);
        chk("wrap_pcplus2", pcplus2_IFID, 16'h0000);

        // Reset asserted mid-stall/mid-wait
        step();
        enPC = 1'b0; imem_valid = 1'b0;
        step();
        chk("midstall_pc", imem_addr, 16'h0002);
        rst_n = 1'b0;
        #1;
        chk_ifid("mid_rst", 16'h0000, 16'h0800, 1'b0);
        chk("mid_rst_pcplus2", pcplus2_IFID, 16'h0000);
        enPC = 1'b1; imem_valid = 1'b1;
        step();
        rst_n = 1'b1;
        chk("mid_rel_pc", imem_addr, 16'h0000);
        step();
        chk_ifid("mid_rel_c1", 16'h0002, 16'hA000, 1'b1);
        chk("mid_rel_pcplus2", pcplus2_IFID, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
